pipe_stage_skid: RTL

Parametrised successor to the fixed-struct ID/EX stage register. It is a generic inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer, so upstream ready depends on registered state only. It has a flush that turns the stage into bubbles, plus an external hold (memory/multi-cycle wait). It sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries a packed payload of arbitrary width.

---
 rtl/pipe_stage_skid_pkg.sv | 13 +
 rtl/pipe_stage_skid.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // PC value instantiators place in bubble payloads of struct-typed stages.
    localparam logic [63:0] STAGE_BUBBLE_PC = 64'h8000_0000;

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer, flush and hold.
// Optional performance counters are enabled by defining PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned      WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int unsigned      CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_is_bubble,
`ifdef PIPE_STAGE_SKID_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] full_cnt,
`endif
    input  logic             hold,
    input  logic             flush
);

    skid_state_t      state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             in_ready_reg;
    logic             accept;
    logic             drain;

    assign out_valid     = (state_reg != SKID_EMPTY);
    assign out_is_bubble = ~out_valid;
    assign out_data      = main_reg;
    assign in_ready      = in_ready_reg;

    assign accept = in_valid & in_ready_reg & ~flush;
    assign drain  = out_valid & out_ready & ~hold;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = SKID_EMPTY;
            main_next  = BUBBLE_VAL;
            skid_next  = BUBBLE_VAL;
        end else begin
            unique case (state_reg)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_next = SKID_ONE;
                        main_next  = in_data;
                    end
                end
                SKID_ONE: begin
                    if (accept && drain) begin
                        main_next = in_data;
                    end else if (accept) begin
                        state_next = SKID_TWO;
                        skid_next  = in_data;
                    end else if (drain) begin
                        state_next = SKID_EMPTY;
                        main_next  = BUBBLE_VAL;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only the drain side can move.
                    if (drain) begin
                        state_next = SKID_ONE;
                        main_next  = skid_reg;
                        skid_next  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_next = SKID_EMPTY;
                    main_next  = BUBBLE_VAL;
                    skid_next  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= SKID_EMPTY;
            main_reg     <= BUBBLE_VAL;
            skid_reg     <= BUBBLE_VAL;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            // Registered from next state so in_ready never sees out_ready/hold combinationally.
            in_ready_reg <= (state_next != SKID_TWO);
        end
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic [CNT_W-1:0] full_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
            full_cnt_reg  <= '0;
        end else begin
            if (out_valid && !drain && !flush)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush && (state_reg != SKID_EMPTY))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            if (state_reg == SKID_TWO)
                full_cnt_reg <= full_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
    assign full_cnt  = full_cnt_reg;
`endif

endmodule
